seq_accumulator: RTL and testbench

SEQ_ACCUMULATOR -- requirements
Module: seq_accumulator

---
 rtl/seq_accumulator.sv | 183 ++++++++++++++++++
 tb/tb_seq_accumulator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_accumulator.sv
// seq_accumulator: packet accumulator built around a carry-select adder.
// Each accepted beat adds an unsigned WIDTH-bit operand into a WIDTH+EXT
// accumulator. The last beat of a packet moves the block into HOLD, where the
// result is presented until the downstream side takes it.
//
// Optional feature macro: SEQ_ACCUMULATOR_SATURATE_EN
//   defined   -> the accumulator saturates to all ones on overflow
//   undefined -> the carry-extension bits wrap on overflow
// In both builds out_ovf is a sticky per-packet overflow flag.

// Carry-select adder: each ADD_WIDTH block precomputes its sum for carry-in
// 0 and 1, and the ripple of block carries only drives the select muxes.
// WIDTH must be a multiple of ADD_WIDTH.
module selected_carry_adder #(
  parameter int WIDTH     = 16,
  parameter int ADD_WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NB = WIDTH / ADD_WIDTH;

  logic [NB:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[NB];

  for (genvar g = 0; g < NB; g++) begin : g_blk
    logic [ADD_WIDTH:0] s0;
    logic [ADD_WIDTH:0] s1;

    assign s0 = {1'b0, a[g*ADD_WIDTH +: ADD_WIDTH]} + {1'b0, b[g*ADD_WIDTH +: ADD_WIDTH]};
    assign s1 = {1'b0, a[g*ADD_WIDTH +: ADD_WIDTH]} + {1'b0, b[g*ADD_WIDTH +: ADD_WIDTH]}
              + (ADD_WIDTH+1)'(1);

    assign sum[g*ADD_WIDTH +: ADD_WIDTH] = carry[g] ? s1[ADD_WIDTH-1:0] : s0[ADD_WIDTH-1:0];
    assign carry[g+1]                    = carry[g] ? s1[ADD_WIDTH]     : s0[ADD_WIDTH];
  end

endmodule

module seq_accumulator #(
  parameter int WIDTH     = 16,
  parameter int ADD_WIDTH = 4,
  parameter int EXT       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH+EXT-1:0] out_sum,
  output logic                 out_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   acc_lo_nxt;
  logic [EXT-1:0]     acc_hi;
  logic [EXT-1:0]     acc_hi_nxt;
  logic               ovf;
  logic               ovf_nxt;

  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic               accept;
  logic               drain;
  logic               ovf_event;

  // Upper extension bits count the carries out of the low adder, modulo 2^EXT.
  function automatic logic [EXT-1:0] hi_step(input logic [EXT-1:0] hi, input logic c);
    return hi + EXT'(c);
  endfunction

`ifdef SEQ_ACCUMULATOR_SATURATE_EN
  // Once the packet has overflowed, the whole accumulator is pinned at all ones.
  function automatic logic [WIDTH+EXT-1:0] saturate(input logic sat,
                                                    input logic [WIDTH+EXT-1:0] val);
    return sat ? {(WIDTH+EXT){1'b1}} : val;
  endfunction
`endif

  // Low part of the running sum goes through the carry-select adder.
  selected_carry_adder #(
    .WIDTH     (WIDTH),
    .ADD_WIDTH (ADD_WIDTH)
  ) u_adder (
    .a    (acc_lo),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign accept    = in_valid && in_ready;
  assign drain     = (state == HOLD) && out_ready;
  assign ovf_event = add_cout && (&acc_hi);

  assign out_sum = {acc_hi, acc_lo};
  assign out_ovf = ovf;

  // State register; reset lands in IDLE so in_ready is high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; clear overrides every other transition.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = in_last ? HOLD : ACC;
      end
      ACC: begin
        if (accept && in_last) state_nxt = HOLD;
      end
      HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Next accumulator value: zero on clear or result handoff, else add the beat.
  always_comb begin
    acc_lo_nxt = acc_lo;
    acc_hi_nxt = acc_hi;
    ovf_nxt    = ovf;
    if (clear || drain) begin
      acc_lo_nxt = '0;
      acc_hi_nxt = '0;
      ovf_nxt    = 1'b0;
    end else if (accept) begin
`ifdef SEQ_ACCUMULATOR_SATURATE_EN
      {acc_hi_nxt, acc_lo_nxt} = saturate(ovf || ovf_event,
                                          {hi_step(acc_hi, add_cout), add_sum});
`else
      acc_lo_nxt = add_sum;
      acc_hi_nxt = hi_step(acc_hi, add_cout);
`endif
      ovf_nxt = ovf || ovf_event;
    end
  end

  // Accumulator and sticky overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_lo <= '0;
      acc_hi <= '0;
      ovf    <= 1'b0;
    end else begin
      acc_lo <= acc_lo_nxt;
      acc_hi <= acc_hi_nxt;
      ovf    <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_seq_accumulator.sv
// Testbench for seq_accumulator (WIDTH=16, ADD_WIDTH=4, EXT=4).
// Expected results come from the arithmetic packet total: overflow means the
// total reached 2^(WIDTH+EXT); the reported sum either wraps or saturates
// depending on SEQ_ACCUMULATOR_SATURATE_EN.
module tb_seq_accumulator;

  localparam int WIDTH     = 16;
  localparam int ADD_WIDTH = 4;
  localparam int EXT       = 4;
  localparam int SW        = WIDTH + EXT;
  localparam longint LIM   = 64'd1 << SW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [WIDTH-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic          out_ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_accumulator #(.WIDTH(WIDTH), .ADD_WIDTH(ADD_WIDTH), .EXT(EXT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  function automatic logic model_ovf(input longint total);
    return total >= LIM;
  endfunction

  function automatic logic [SW-1:0] model_sum(input longint total);
`ifdef SEQ_ACCUMULATOR_SATURATE_EN
    if (total >= LIM) return {SW{1'b1}};
`endif
    return SW'(total % LIM);
  endfunction

  // One beat presented for exactly one rising edge; returns at edge+1.
  task automatic drive_beat(input logic [WIDTH-1:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    n_cmp++; if (out_sum !== '0 || out_ovf !== 1'b0) begin n_err++;
      $display("FAIL reset_acc: sum=%h ovf=%b expected 0/0", out_sum, out_ovf); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0) begin n_err++;
      $display("FAIL reset_release: vld=%b rdy=%b sum=%h expected 0/1/0", out_valid, in_ready, out_sum); end
  endtask

  task automatic test_basic();
    drive_beat(16'h0001, 1'b0);
    drive_beat(16'h0002, 1'b0);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 20'h00003) begin n_err++;
      $display("FAIL basic_mid: vld=%b rdy=%b sum=%h expected 0/1/00003", out_valid, in_ready, out_sum); end
    drive_beat(16'h0003, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_sum !== 20'h00006 || out_ovf !== 1'b0) begin n_err++;
      $display("FAIL basic_result: vld=%b sum=%h ovf=%b expected 1/00006/0", out_valid, out_sum, out_ovf); end
    take_result();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0) begin n_err++;
      $display("FAIL basic_drain: vld=%b rdy=%b sum=%h expected 0/1/0", out_valid, in_ready, out_sum); end
  endtask

  task automatic test_carry();
    drive_beat(16'hFFFF, 1'b0);
    drive_beat(16'h0001, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_sum !== 20'h10000 || out_ovf !== 1'b0) begin n_err++;
      $display("FAIL carry_result: vld=%b sum=%h ovf=%b expected 1/10000/0", out_valid, out_sum, out_ovf); end
    take_result();
  endtask

  task automatic test_overflow();
    logic [SW-1:0] exp_s;
    for (int i = 0; i < 16; i++) drive_beat(16'hFFFF, 1'b0);
    n_cmp++; if (out_sum !== 20'hFFFF0 || out_ovf !== 1'b0) begin n_err++;
      $display("FAIL ovf_pre: sum=%h ovf=%b expected FFFF0/0", out_sum, out_ovf); end
    drive_beat(16'hFFFF, 1'b1);
`ifdef SEQ_ACCUMULATOR_SATURATE_EN
    exp_s = 20'hFFFFF;
`else
    exp_s = 20'h0FFEF;
`endif
    n_cmp++; if (out_valid !== 1'b1 || out_sum !== exp_s || out_ovf !== 1'b1) begin n_err++;
      $display("FAIL ovf_result: vld=%b sum=%h ovf=%b expected 1/%h/1", out_valid, out_sum, out_ovf, exp_s); end
    take_result();
    n_cmp++; if (out_ovf !== 1'b0 || out_sum !== '0) begin n_err++;
      $display("FAIL ovf_drain: sum=%h ovf=%b expected 0/0", out_sum, out_ovf); end
  endtask

  task automatic test_hold();
    drive_beat(16'h1234, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'hAAAA;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 20'h01234) begin n_err++;
        $display("FAIL hold_stable[%0d]: vld=%b rdy=%b sum=%h expected 1/0/01234", i, out_valid, in_ready, out_sum); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    take_result();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || out_ovf !== 1'b0) begin n_err++;
      $display("FAIL hold_drain: vld=%b rdy=%b sum=%h ovf=%b expected 0/1/0/0", out_valid, in_ready, out_sum, out_ovf); end
  endtask

  task automatic test_clear();
    drive_beat(16'h0010, 1'b0);
    drive_beat(16'h0020, 1'b0);
    clear = 1'b1;
    drive_beat(16'h0030, 1'b0);
    clear = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || out_ovf !== 1'b0) begin n_err++;
      $display("FAIL clear_mid: vld=%b rdy=%b sum=%h ovf=%b expected 0/1/0/0", out_valid, in_ready, out_sum, out_ovf); end
    drive_beat(16'h0005, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_sum !== 20'h00005) begin n_err++;
      $display("FAIL clear_next: vld=%b sum=%h expected 1/00005", out_valid, out_sum); end
    clear     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    clear     = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out_sum !== '0) begin n_err++;
      $display("FAIL clear_hold: vld=%b sum=%h expected 0/0", out_valid, out_sum); end
    // Clear on the edge that carries a last beat must still win.
    drive_beat(16'h0009, 1'b0);
    clear = 1'b1;
    drive_beat(16'h0001, 1'b1);
    clear = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out_sum !== '0) begin n_err++;
      $display("FAIL clear_last: vld=%b sum=%h expected 0/0", out_valid, out_sum); end
  endtask

  task automatic test_async_reset();
    drive_beat(16'h0100, 1'b0);
    drive_beat(16'h0200, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_sum !== '0 || in_ready !== 1'b1) begin n_err++;
      $display("FAIL arst_mid: vld=%b sum=%h rdy=%b expected 0/0/1", out_valid, out_sum, in_ready); end
    #2 rst_n = 1'b1;
    #1;
    drive_beat(16'h0042, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_sum !== 20'h00042) begin n_err++;
      $display("FAIL arst_first_beat: vld=%b sum=%h expected 1/00042", out_valid, out_sum); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_sum !== '0 || in_ready !== 1'b1) begin n_err++;
      $display("FAIL arst_hold: vld=%b sum=%h rdy=%b expected 0/0/1", out_valid, out_sum, in_ready); end
    #2 rst_n = 1'b1;
    #1;
    idle_cycle();
  endtask

  task automatic test_random(input int npk, input bit gaps);
    for (int p = 0; p < npk; p++) begin
      int len;
      bit heavy;
      longint total;
      logic [WIDTH-1:0] d;
      logic [SW-1:0] exp_s;
      logic exp_o;
      int hold_cyc;
      heavy = 1'($urandom_range(0, 1));
      len   = heavy ? int'($urandom_range(14, 20)) : int'($urandom_range(1, 8));
      total = 0;
      for (int b = 0; b < len; b++) begin
        d = heavy ? WIDTH'($urandom_range(16'hF000, 16'hFFFF)) : WIDTH'($urandom);
        total += longint'(d);
        if (gaps && $urandom_range(0, 2) == 0) idle_cycle();
        drive_beat(d, b == len - 1);
        if (b != len - 1) begin
          n_cmp++; if (out_valid !== 1'b0 || out_sum !== model_sum(total)) begin n_err++;
            $display("FAIL rand_partial[%0d.%0d]: vld=%b sum=%h expected 0/%h", p, b, out_valid, out_sum, model_sum(total)); end
        end
      end
      exp_s = model_sum(total);
      exp_o = model_ovf(total);
      hold_cyc = gaps ? int'($urandom_range(0, 3)) : 0;
      in_valid = 1'b1;
      in_data  = WIDTH'($urandom);
      for (int h = 0; h <= hold_cyc; h++) begin
        n_cmp++; if (out_valid !== 1'b1 || out_sum !== exp_s || out_ovf !== exp_o) begin n_err++;
          $display("FAIL rand_result[%0d]: vld=%b sum=%h ovf=%b expected 1/%h/%b", p, out_valid, out_sum, out_ovf, exp_s, exp_o); end
        if (h < hold_cyc) begin
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b0;
      take_result();
    end
  endtask

  task automatic test_back_to_back();
    test_random(4, 1'b0);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0) begin n_err++;
      $display("FAIL b2b_end: vld=%b rdy=%b sum=%h expected 0/1/0", out_valid, in_ready, out_sum); end
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_overflow();
    test_hold();
    test_clear();
    test_async_reset();
    test_back_to_back();
    test_random(25, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
